// File: rtl/dp_ram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for dp_ram_fifo_ctrl.
//   master : the stream side (drives wr_valid/wr_data/rd_ready)
//   slave  : the FIFO controller (drives wr_ready/rd_valid/rd_data)
interface dp_ram_fifo_ctrl_if #(
  parameter int Data_width = 8
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [Data_width-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [Data_width-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external single-clock
// dual-port RAM (registered read, 1-cycle latency, read-before-write).
// Ports:
//   i_clk, i_reset      rising-edge clock, synchronous active-high reset
//   bus (slave)         wr_valid/wr_ready/wr_data, rd_valid/rd_ready/rd_data
//   o_ram_we/o_ram_w_addr/o_ram_d   RAM write port
//   o_ram_r_addr, i_ram_q           RAM read port (q is the head word)
//   o_level             words accepted and not yet popped
//   o_almost_full       level >= Afull_thresh
//   o_overflow_err      sticky, set by a write attempt while full
module dp_ram_fifo_ctrl #(
  parameter int Data_width   = 8,
  parameter int Addr_width   = 10,
  parameter int Afull_thresh = 2**Addr_width - 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  dp_ram_fifo_ctrl_if.slave     bus,
  output logic                  o_ram_we,
  output logic [Addr_width-1:0] o_ram_w_addr,
  output logic [Addr_width-1:0] o_ram_r_addr,
  output logic [Data_width-1:0] o_ram_d,
  input  logic [Data_width-1:0] i_ram_q,
  output logic [Addr_width:0]   o_level,
  output logic                  o_almost_full,
  output logic                  o_overflow_err
);

  localparam logic [Addr_width:0] L_DEPTH = {1'b1, {Addr_width{1'b0}}};
  localparam logic [Addr_width:0] L_AFULL = Afull_thresh[Addr_width:0];

  logic [Addr_width-1:0] r_wr_ptr;
  logic [Addr_width-1:0] r_rd_ptr;
  logic [Addr_width:0]   r_level;
  // Words whose RAM read has had time to complete; always <= r_level.
  logic [Addr_width:0]   r_vis_count;
  // Second stage of the visibility pipe (first stage is the push itself).
  logic                  r_push_d;
  logic                  r_overflow_err;

  logic w_full;
  logic w_rd_valid;
  logic w_push;
  logic w_pop;

  // Handshake decode and RAM port drive.
  always_comb begin
    w_full     = (r_level == L_DEPTH);
    w_rd_valid = 1'b0;
    if (!i_reset) begin
      w_rd_valid = (r_vis_count != {(Addr_width+1){1'b0}});
    end else begin
      w_rd_valid = 1'b0;
    end
    // Readiness comes only from registered state: a pop this cycle does not
    // free a slot for a push in the same cycle.
    bus.wr_ready = !i_reset && !w_full;
    bus.rd_valid = w_rd_valid;
    bus.rd_data  = i_ram_q;
    w_push       = bus.wr_valid & bus.wr_ready;
    w_pop        = w_rd_valid & bus.rd_ready;

    o_ram_we     = w_push;
    o_ram_w_addr = r_wr_ptr;
    o_ram_d      = bus.wr_data;
    // Prefetch the next head on pop so ram_q always tracks r_rd_ptr and
    // back-to-back pops need no bubble.
    if (w_pop) begin
      o_ram_r_addr = r_rd_ptr + {{(Addr_width-1){1'b0}}, 1'b1};
    end else begin
      o_ram_r_addr = r_rd_ptr;
    end
  end

  // Pointer, occupancy, visibility and error-flag state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr       <= {Addr_width{1'b0}};
      r_rd_ptr       <= {Addr_width{1'b0}};
      r_level        <= {(Addr_width+1){1'b0}};
      r_vis_count    <= {(Addr_width+1){1'b0}};
      r_push_d       <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(Addr_width-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(Addr_width-1){1'b0}}, 1'b1};
      end
      r_level <= r_level + {{Addr_width{1'b0}}, w_push}
                         - {{Addr_width{1'b0}}, w_pop};
      // A word written at edge t is captured by the RAM read register at
      // edge t+1, so it may be counted visible from that edge on. This also
      // masks the read-before-write collision in the push cycle.
      r_push_d    <= w_push;
      r_vis_count <= r_vis_count + {{Addr_width{1'b0}}, r_push_d}
                                 - {{Addr_width{1'b0}}, w_pop};
      if (bus.wr_valid && w_full) begin
        r_overflow_err <= 1'b1;
      end
    end
  end

  assign o_level        = r_level;
  assign o_almost_full  = !i_reset && (r_level >= L_AFULL);
  assign o_overflow_err = r_overflow_err;

endmodule

// File: doc/dp_ram_fifo_ctrl.md
Name: dp_ram_fifo_ctrl

Overview:
Controller that turns the team's single-clock dual-port RAM (1 write port, 1 registered read port with 1-cycle latency, read-before-write on address collision) into a first-word-fall-through FIFO. It owns the write and read pointers and drives RAM we/w_addr/r_addr. It hides the RAM read latency behind valid/ready handshakes on both sides. Sits between a producer stream and a consumer stream; the RAM instance is external and wired to the ram_* ports.

Parameters:
Data_width, 8, bits per word (must match RAM)
Addr_width, 10, RAM address bits; DEPTH = 2**Addr_width
Afull_thresh, 2**Addr_width-4, level at or above which almost_full asserts

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
wr_valid  input  1  producer has a word
wr_ready  output  1  FIFO can accept a word
wr_data  input  Data_width  producer word
rd_valid  output  1  rd_data holds the head word
rd_ready  input  1  consumer takes head word
rd_data  output  Data_width  head word
ram_we  output  1  to RAM we
ram_w_addr  output  Addr_width  to RAM w_addr
ram_r_addr  output  Addr_width  to RAM r_addr
ram_d  output  Data_width  to RAM d
ram_q  input  Data_width  from RAM q
level  output  Addr_width+1  words accepted and not yet popped
almost_full  output  1  level >= Afull_thresh
overflow_err  output  1  sticky: wr_valid high while full

Behaviour:
- Reset: wr_ptr, rd_ptr, level, vis_count, write-pipe flags, overflow_err all 0. During reset: wr_ready=0, rd_valid=0, ram_we=0, almost_full=0. RAM contents not cleared. Reset mid-operation discards all stored and in-flight words.
- push = wr_valid & wr_ready; pop = rd_valid & rd_ready.
- wr_ready = !reset & (level < DEPTH). Depends only on registered state; pop in the same cycle does not open a slot (no pass-through when full).
- Write path combinational: ram_we = push, ram_w_addr = wr_ptr, ram_d = wr_data. wr_ptr increments on push, wraps DEPTH-1 -> 0.
- Read address: ram_r_addr = pop ? rd_ptr+1 (mod DEPTH) : rd_ptr. rd_ptr increments on pop, wraps. Hence ram_q in cycle t+1 is always the word at rd_ptr of cycle t+1; back-to-back pops need no bubble.
- rd_data = ram_q (no extra register).
- Visibility: a word pushed in cycle t is readable from ram_q at cycle t+2 at the earliest (RAM write at edge t, read register at edge t+1). Two-stage shift pipe of push flags; vis_count += pipe stage-2 flag, -= pop. rd_valid = (vis_count != 0).
- level += push, -= pop; simultaneous push and pop leave level unchanged. vis_count <= level always.
- Write-to-read latency into an empty FIFO: 2 cycles (push at t -> rd_valid at t+2).
- Collision: when w_addr == r_addr in the same cycle the RAM returns old data; the visibility pipe guarantees that word is never presented as valid.
- overflow_err sets when wr_valid=1 and level==DEPTH; clears only on reset. The word is not written.
- almost_full combinational from level.
- Pop while rd_valid=0 is impossible by definition; rd_ready is ignored then.

Test Plan:
- Addr_width=2: after reset, push 0x11 at cycle 0 -> rd_valid=0 at cycles 0-1, =1 with rd_data=0x11 at cycle 2; level=1 at cycle 1.
- Push 4 words 0xA0..0xA3 with rd_ready=0 -> level=4, wr_ready=0, almost_full=1 (thresh 0); wr_valid held 1 more cycle -> overflow_err=1, RAM unchanged.
- Full FIFO, rd_ready=1 continuously -> 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles, then rd_valid=0, level=0.
- Continuous push and pop from empty for 10 words (0x00..0x09) -> output order 0x00..0x09 across pointer wrap, level steady at 2 after fill, no gap after first valid.
- Reset asserted with level=3 mid-stream -> next cycle level=0, rd_valid=0, overflow_err=0; push 0x5A afterwards reads back 0x5A 2 cycles later.
- Push into empty with rd_ready=1 at t+1 (rd_valid still 0) -> no pop, no pointer move; word read at t+2.
